limber_gnrl_debounce: RTL and testbench

Per-lane glitch filter and edge detector placed directly downstream of the DFF-chain synchronizer. It consumes the synchronized bus `so` from the DFF chain, driven into `si` here. Each lane forwards a level change only after the new value has been sampled for `STABLE_CNT` consecutive enabled cycles. It also emits single-cycle rise/fall pulses for downstream control logic such as button handling, interrupt lines and external strobes.

---
 rtl/limber_gnrl_debounce_if.sv | 27 ++
 rtl/limber_gnrl_debounce.sv | 82 ++++++++
 tb/tb_limber_gnrl_debounce.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/limber_gnrl_debounce_if.sv
// Signal bundle between a synchronizer-fed consumer and the debounce block.
// The consumer side drives the raw lanes and the sample tick; the block returns level and edges.
interface limber_gnrl_debounce_if #(
  parameter int DW = 1
);
  logic          en;
  logic [DW-1:0] si;
  logic [DW-1:0] so;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;

  modport master (
    output en,
    output si,
    input  so,
    input  rise,
    input  fall
  );

  modport slave (
    input  en,
    input  si,
    output so,
    output rise,
    output fall
  );
endinterface

// File: rtl/limber_gnrl_debounce.sv
// Per-lane glitch filter with registered rise/fall pulses.
// A lane adopts a new level only after STABLE_CNT consecutive enabled samples disagree with it.
module limber_gnrl_debounce #(
  parameter int            DW         = 1,
  parameter int            STABLE_CNT = 8,
  parameter int            CW         = 4,
  parameter logic [DW-1:0] RST_VAL    = '0
) (
  input logic                   clk,
  input logic                   rst_syn,
  limber_gnrl_debounce_if.slave dbus
);

  // Count value on which the next differing sample is accepted; STABLE_CNT=2^CW still fits.
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CNT - 1);

  logic [DW-1:0] so_vec;
  logic [DW-1:0] rise_vec;
  logic [DW-1:0] fall_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_lane
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          so_reg;
      logic          so_next;
      logic          rise_reg;
      logic          rise_next;
      logic          fall_reg;
      logic          fall_next;
      logic          differ;
      logic          accept;

      always_ff @(posedge clk) begin
        if (rst_syn) begin
          so_reg   <= RST_VAL[gi];
          cnt_reg  <= '0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          so_reg   <= so_next;
          cnt_reg  <= cnt_next;
          rise_reg <= rise_next;
          fall_reg <= fall_next;
        end
      end

      // A matching sample drops straight back to the idle count, which is what rejects glitches.
      always_comb begin
        differ   = dbus.si[gi] ^ so_reg;
        accept   = dbus.en && differ && (cnt_reg == LAST_CNT);
        cnt_next = cnt_reg;
        so_next  = so_reg;
        if (dbus.en) begin
          if (!differ || accept) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
          if (accept) begin
            so_next = dbus.si[gi];
          end
        end
      end

      always_comb begin
        rise_next = accept && dbus.si[gi];
        fall_next = accept && !dbus.si[gi];
      end

      assign so_vec[gi]   = so_reg;
      assign rise_vec[gi] = rise_reg;
      assign fall_vec[gi] = fall_reg;
    end
  endgenerate

  assign dbus.so   = so_vec;
  assign dbus.rise = rise_vec;
  assign dbus.fall = fall_vec;

endmodule

// File: tb/tb_limber_gnrl_debounce.sv
// Three debounce instances (STABLE_CNT 8, 1, 16) share one stimulus stream and are
// compared each cycle against a sample-window reference model.
module tb_limber_gnrl_debounce;

  localparam int DW   = 4;
  localparam int NDUT = 3;

  localparam logic [DW-1:0] RST_A = 4'b0110;
  localparam logic [DW-1:0] RST_B = 4'b0000;
  localparam logic [DW-1:0] RST_C = 4'b1111;

  logic          clk = 1'b0;
  logic          rst_drv = 1'b1;
  logic          en_drv = 1'b0;
  logic [DW-1:0] si_drv = '0;

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc    = 0;

  always #5 clk = ~clk;

  limber_gnrl_debounce_if #(.DW(DW)) if_a ();
  limber_gnrl_debounce_if #(.DW(DW)) if_b ();
  limber_gnrl_debounce_if #(.DW(DW)) if_c ();

  assign if_a.en = en_drv;
  assign if_a.si = si_drv;
  assign if_b.en = en_drv;
  assign if_b.si = si_drv;
  assign if_c.en = en_drv;
  assign if_c.si = si_drv;

  limber_gnrl_debounce #(.DW(DW), .STABLE_CNT(8),  .CW(4), .RST_VAL(RST_A)) u_dut_a (
    .clk     (clk),
    .rst_syn (rst_drv),
    .dbus    (if_a)
  );
  limber_gnrl_debounce #(.DW(DW), .STABLE_CNT(1),  .CW(4), .RST_VAL(RST_B)) u_dut_b (
    .clk     (clk),
    .rst_syn (rst_drv),
    .dbus    (if_b)
  );
  limber_gnrl_debounce #(.DW(DW), .STABLE_CNT(16), .CW(4), .RST_VAL(RST_C)) u_dut_c (
    .clk     (clk),
    .rst_syn (rst_drv),
    .dbus    (if_c)
  );

  logic [DW-1:0] obs_so   [NDUT];
  logic [DW-1:0] obs_rise [NDUT];
  logic [DW-1:0] obs_fall [NDUT];
  assign obs_so[0]   = if_a.so;
  assign obs_rise[0] = if_a.rise;
  assign obs_fall[0] = if_a.fall;
  assign obs_so[1]   = if_b.so;
  assign obs_rise[1] = if_b.rise;
  assign obs_fall[1] = if_b.fall;
  assign obs_so[2]   = if_c.so;
  assign obs_rise[2] = if_c.rise;
  assign obs_fall[2] = if_c.fall;

  // Reference model: each lane remembers the enabled samples seen since its last reset or
  // accept, and accepts once the most recent N of them all disagree with the current level.
  int            n_tab   [NDUT];
  logic [DW-1:0] rst_tab [NDUT];
  logic [DW-1:0] m_so    [NDUT];
  logic [DW-1:0] m_rise  [NDUT];
  logic [DW-1:0] m_fall  [NDUT];
  logic [31:0]   hist    [NDUT][DW];
  int            seen    [NDUT][DW];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [DW-1:0] s);
    logic [31:0] mask;
    logic [31:0] want;
    for (int d = 0; d < NDUT; d++) begin
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int k = 0; k < DW; k++) begin
        if (r) begin
          m_so[d][k] = rst_tab[d][k];
          hist[d][k] = '0;
          seen[d][k] = 0;
        end else if (e) begin
          hist[d][k] = {hist[d][k][30:0], s[k]};
          if (seen[d][k] < 32) seen[d][k]++;
          mask = (32'd1 << n_tab[d]) - 32'd1;
          want = m_so[d][k] ? 32'd0 : mask;
          if (seen[d][k] >= n_tab[d] && (hist[d][k] & mask) == want) begin
            m_so[d][k]   = s[k];
            m_rise[d][k] = s[k];
            m_fall[d][k] = !s[k];
            seen[d][k]   = 0;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive, advance model, sample 1 time unit after the edge, compare.
  task automatic cyc(input logic r, input logic e, input logic [DW-1:0] s);
    rst_drv = r;
    en_drv  = e;
    si_drv  = s;
    model_step(r, e, s);
    @(posedge clk);
    #1;
    n_cyc++;
    $display("cyc %0d rst=%b en=%b si=%b | a so=%b r=%b f=%b | b so=%b | c so=%b",
             n_cyc, r, e, s, obs_so[0], obs_rise[0], obs_fall[0], obs_so[1], obs_so[2]);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("so_d%0d", d),   32'(obs_so[d]),   32'(m_so[d]));
      check_eq($sformatf("rise_d%0d", d), 32'(obs_rise[d]), 32'(m_rise[d]));
      check_eq($sformatf("fall_d%0d", d), 32'(obs_fall[d]), 32'(m_fall[d]));
    end
  endtask

  initial begin
    logic [DW-1:0] s;
    int            rate;
    n_tab[0] = 8;  rst_tab[0] = RST_A;
    n_tab[1] = 1;  rst_tab[1] = RST_B;
    n_tab[2] = 16; rst_tab[2] = RST_C;
    for (int d = 0; d < NDUT; d++) begin
      m_so[d]   = 'x;
      m_rise[d] = 'x;
      m_fall[d] = 'x;
    end

    // Reset held three cycles with all lanes high, then released with en high.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 4'b1111);

    // Settle low, then a 7-sample glitch, a gap, and an 8-sample real change.
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 7; i++)  cyc(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 8; i++)  cyc(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'b1111);

    // Falling edge with en toggling every cycle.
    for (int i = 0; i < 40; i++) cyc(1'b0, (i % 2 == 0), 4'b0000);

    // Mid-count reset: five differing samples, reset, then held.
    for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b1, 4'b1001);
    cyc(1'b1, 1'b1, 4'b1001);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'b1001);

    // Lane 0 flips every 3 cycles while lane 1 holds high.
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, {2'b00, 1'b1, 1'((i / 3) % 2)});
    for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b1, 4'b1010);

    // Randomized traffic with a per-block toggle rate and occasional reset.
    s = si_drv;
    for (int blk = 0; blk < 30; blk++) begin
      rate = $urandom_range(2, 24);
      for (int i = 0; i < 100; i++) begin
        for (int k = 0; k < DW; k++) begin
          if ($urandom_range(0, rate - 1) == 0) s[k] = ~s[k];
        end
        cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) != 0), s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
